// File: rtl/rf_dump_pkg.sv
// Shared definitions for the register-file dump sequencer and the register file it taps.
// Holds the state encoding and the default read-port widths.
package rf_dump_pkg;

   localparam int RF_ADDR_W = 5;
   localparam int RF_DATA_W = 32;

   typedef logic [2:0] state_t;

   localparam state_t IDLE   = 3'd0;
   localparam state_t FREEZE = 3'd1;
   localparam state_t READ   = 3'd2;
   localparam state_t SHOW   = 3'd3;
   localparam state_t DONE   = 3'd4;

endpackage

// File: rtl/rf_dump_ctrl_edge_detect.sv
// Registers a clk-synchronous level and flags its rising edge; rise is combinational, 0-cycle.
// No backpressure: the pulse lasts one cycle and is lost if the consumer is not listening.
module rf_dump_ctrl_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise
);

   logic sig_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sig_q <= 1'b0;
      else      sig_q <= sig;
   end

   assign rise = sig & ~sig_q;

endmodule

// File: rtl/rf_dump_ctrl.sv
// Stalls the core, drains it, then walks the register file onto the display; each value captured 1 cycle after its READ.
// No backpressure on the display; DUMP_STEP_EN makes each step wait for a button rising edge instead of the hold timer.
module rf_dump_ctrl
   import rf_dump_pkg::*;
#(
   parameter int NUM_REGS    = 32,
   parameter int ADDR_W      = RF_ADDR_W,
   parameter int DATA_W      = RF_DATA_W,
   parameter int FIRST_REG   = 0,
   parameter int HOLD_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              button,
   input  logic              dump_req,
   input  logic              abort,
   input  logic              core_quiet,
   input  logic [ADDR_W-1:0] core_rd_addr,
   input  logic [DATA_W-1:0] rf_rd_data,
   output logic [ADDR_W-1:0] rf_rd_addr,
   output logic              core_stall,
   output logic [DATA_W-1:0] out,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_idx,
   output logic              done
);

   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
   localparam logic [CNT_W-1:0]  HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] idx;
   logic [CNT_W-1:0]  cnt;
   logic              btn_rise;
   logic              start;
   logic              advance;
   logic              last;
   logic              abortable;

   rf_dump_ctrl_edge_detect u_btn (
      .clk  (clk),
      .rst  (rst),
      .sig  (button),
      .rise (btn_rise)
   );

   assign start     = dump_req | btn_rise;
   assign last      = (idx == LAST_IDX);
   assign abortable = (state == FREEZE) || (state == READ) || (state == SHOW);

`ifdef DUMP_STEP_EN
   assign advance = btn_rise;
`else
   assign advance = (cnt == '0);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // abort outranks every transition out of FREEZE/READ/SHOW
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = FREEZE;
         FREEZE:  if (abort) state_nxt = IDLE;
                  else if (core_quiet) state_nxt = READ;
         READ:    state_nxt = abort ? IDLE : SHOW;
         SHOW:    if (abort) state_nxt = IDLE;
                  else if (advance) state_nxt = last ? DONE : READ;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      core_stall = 1'b0;
      done       = 1'b0;
      rf_rd_addr = core_rd_addr;
      case (state)
         FREEZE: core_stall = 1'b1;
         READ, SHOW: begin
            core_stall = 1'b1;
            rf_rd_addr = idx;
         end
         DONE:   done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx       <= '0;
         cnt       <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         out_idx   <= '0;
      end else if (abort && abortable) begin
         out_valid <= 1'b0;
      end else begin
         case (state)
            FREEZE: if (core_quiet) idx <= FIRST_IDX;
            READ: begin
               out       <= rf_rd_data;
               out_idx   <= idx;
               out_valid <= 1'b1;
               cnt       <= HOLD_INIT;
            end
            SHOW: begin
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
               if (advance && !last) idx <= idx + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rf_dump_ctrl.sv
// Scoreboard bench for rf_dump_ctrl: stimulus queues expected display values and done pulses,
// a negedge monitor pops and compares them whenever the DUT presents a new value or pulses done.
module tb_rf_dump_ctrl;

   localparam int NR   = 32;
   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int HOLD = 4;

   typedef struct {
      bit          kind;   // 0 = displayed value, 1 = done pulse
      int          idx;
      logic [31:0] data;
      int          gap;    // required cycles since previous presentation, 0 = unchecked
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          button;
   logic          dump_req;
   logic          abort;
   logic          core_quiet;
   logic [AW-1:0] core_rd_addr;
   logic [DW-1:0] rf_rd_data;
   logic [AW-1:0] rf_rd_addr;
   logic          core_stall;
   logic [DW-1:0] out;
   logic          out_valid;
   logic [AW-1:0] out_idx;
   logic          done;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_cyc = 0;
   int   pat = 0;
   logic prev_valid = 1'b0;
   logic [AW-1:0] prev_idx = '0;
   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   rf_dump_ctrl #(
      .NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .FIRST_REG(0), .HOLD_CYCLES(HOLD)
   ) dut (
      .clk(clk), .rst(rst), .button(button), .dump_req(dump_req), .abort(abort),
      .core_quiet(core_quiet), .core_rd_addr(core_rd_addr), .rf_rd_data(rf_rd_data),
      .rf_rd_addr(rf_rd_addr), .core_stall(core_stall), .out(out), .out_valid(out_valid),
      .out_idx(out_idx), .done(done)
   );

   function automatic logic [31:0] pat_val(input int p, input int k);
      if (p == 0)      return 32'(k * 3);
      else if (p == 1) return 32'hC0DE_0000 + 32'(k);
      else             return 32'h5A5A_0000 ^ 32'(k << 4);
   endfunction

   assign rf_rd_data = pat_val(pat, int'(rf_rd_addr));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_dump(input int p, input int first, input int last,
                            input bit with_done, input bit timed);
      exp_t e;
      for (int k = first; k <= last; k++) begin
         e.kind = 1'b0;
         e.idx  = k;
         e.data = pat_val(p, k);
         e.gap  = (k == first || !timed) ? 0 : HOLD + 1;
         exp_q.push_back(e);
      end
      if (with_done) begin
         e.kind = 1'b1;
         e.idx  = 0;
         e.data = '0;
         e.gap  = timed ? HOLD : 0;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_drain(input int limit);
      int n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         @(posedge clk);
         n++;
      end
      chk("drain_pending", 64'(exp_q.size()), 64'd0);
      #1;
      repeat (2) tick();
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         prev_valid = 1'b0;
      end else begin
         if (out_valid && (!prev_valid || out_idx != prev_idx)) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_out: idx %0d value %0h shown, nothing expected", out_idx, out);
            end else begin
               e = exp_q.pop_front();
               chk("out_kind", 64'd0, 64'(e.kind));
               chk("out_idx", 64'(out_idx), 64'(e.idx));
               chk("out_data", 64'(out), 64'(e.data));
               if (e.gap != 0) chk("out_hold", 64'(cyc - last_cyc), 64'(e.gap));
            end
            last_cyc = cyc;
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_done: done pulsed, none expected");
            end else begin
               e = exp_q.pop_front();
               chk("done_kind", 64'd1, 64'(e.kind));
               chk("done_stall", 64'(core_stall), 64'd0);
               if (e.gap != 0) chk("done_gap", 64'(cyc - last_cyc), 64'(e.gap));
            end
         end
         prev_valid = out_valid;
         prev_idx   = out_idx;
      end
   end

   initial begin
      rst = 1'b0; button = 1'b0; dump_req = 1'b0; abort = 1'b0;
      core_quiet = 1'b1; core_rd_addr = 5'd7;
      repeat (3) tick();
      chk("rst_stall", 64'(core_stall), 64'd0);
      chk("rst_out", 64'(out), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_idx", 64'(out_idx), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_addr", 64'(rf_rd_addr), 64'd7);
      rst = 1'b1;
      repeat (2) tick();

`ifdef DUMP_STEP_EN
      pat = 0;
      push_dump(0, 0, 0, 1'b0, 1'b0);
      button = 1'b1; tick(); button = 1'b0;
      repeat (10) tick();
      chk("step_first_idx", 64'(out_idx), 64'd0);
      chk("step_stall", 64'(core_stall), 64'd1);
      for (int p = 1; p <= 3; p++) begin
         push_dump(0, p, p, 1'b0, 1'b0);
         button = 1'b1; tick(); button = 1'b0;
         repeat (5) tick();
         chk("step_idx", 64'(out_idx), 64'(p));
         chk("step_data", 64'(out), 64'(p * 3));
      end
      repeat (100) tick();
      chk("step_hold_idx", 64'(out_idx), 64'd3);
      chk("step_hold_stall", 64'(core_stall), 64'd1);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("step_abort_stall", 64'(core_stall), 64'd0);
      wait_drain(50);
`else
      // full timed dump, core already quiet
      pat = 0;
      push_dump(0, 0, NR - 1, 1'b1, 1'b1);
      dump_req = 1'b1;
      #1 chk("pre_edge_stall", 64'(core_stall), 64'd0);
      @(posedge clk); #1 dump_req = 1'b0;
      chk("stall_rise", 64'(core_stall), 64'd1);
      chk("freeze_addr", 64'(rf_rd_addr), 64'd7);
      wait_drain(400);
      chk("idle_stall", 64'(core_stall), 64'd0);
      chk("keep_valid", 64'(out_valid), 64'd1);
      chk("keep_out", 64'(out), 64'd93);
      chk("keep_idx", 64'(out_idx), 64'(NR - 1));

      // pipeline busy: seven FREEZE cycles, core keeps its read port
      pat = 1;
      core_quiet = 1'b0;
      push_dump(1, 0, NR - 1, 1'b1, 1'b1);
      dump_req = 1'b1; tick(); dump_req = 1'b0;
      for (int i = 0; i < 7; i++) begin
         core_rd_addr = 5'(i + 3);
         core_quiet = (i == 6);
         #1;
         chk("freeze_stall", 64'(core_stall), 64'd1);
         chk("freeze_follow", 64'(rf_rd_addr), 64'(i + 3));
         tick();
      end
      core_rd_addr = 5'd9;
      #1 chk("read_addr", 64'(rf_rd_addr), 64'd0);
      wait_drain(400);

      // abort while register 5 is on display
      pat = 2;
      push_dump(2, 0, 5, 1'b0, 1'b1);
      dump_req = 1'b1; tick(); dump_req = 1'b0;
      begin
         int n = 0;
         while (!(out_valid && out_idx == 5'd5) && n < 200) begin
            tick();
            n++;
         end
         chk("reach_reg5", 64'(n < 200), 64'd1);
      end
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort_stall", 64'(core_stall), 64'd0);
      chk("abort_valid", 64'(out_valid), 64'd0);
      repeat (10) tick();
      chk("abort_queue", 64'(exp_q.size()), 64'd0);

      // start and abort together in IDLE: start wins, restart from register 0
      pat = 0;
      push_dump(0, 0, NR - 1, 1'b1, 1'b1);
      dump_req = 1'b1; abort = 1'b1; tick(); dump_req = 1'b0; abort = 1'b0;
      chk("start_over_abort", 64'(core_stall), 64'd1);
      wait_drain(400);

      // asynchronous reset in the middle of a READ cycle
      core_rd_addr = 5'd7;
      dump_req = 1'b1; tick(); dump_req = 1'b0;
      tick();
      chk("midread_addr", 64'(rf_rd_addr), 64'd0);
      chk("midread_stall", 64'(core_stall), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("arst_stall", 64'(core_stall), 64'd0);
      chk("arst_out", 64'(out), 64'd0);
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_idx", 64'(out_idx), 64'd0);
      chk("arst_addr", 64'(rf_rd_addr), 64'd7);
      rst = 1'b1;
      repeat (3) tick();

      // held button starts exactly one dump; a later press mid-dump is ignored
      push_dump(0, 0, NR - 1, 1'b1, 1'b1);
      button = 1'b1; repeat (20) tick(); button = 1'b0;
      repeat (15) tick();
      button = 1'b1; repeat (2) tick(); button = 1'b0;
      wait_drain(400);
      repeat (20) tick();
      chk("button_once_stall", 64'(core_stall), 64'd0);
      chk("button_once_queue", 64'(exp_q.size()), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
